spi_read_sequencer: RTL and testbench

//  Sequences one SPI read transaction over the byte-level SPI TX and RX shifters.

---
 rtl/spi_read_sequencer_if.sv | 35 +++
 rtl/spi_read_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_spi_read_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_read_sequencer_if.sv
// rtl/spi_read_sequencer_if.sv - request, read-stream and SPI shifter signals of the read sequencer
// master is the sequencer side; slave is the client/shifter side.
interface spi_read_sequencer_if #(
  parameter int ADDR_BYTES = 3,
  parameter int LEN_W      = 8
);
  localparam int ADDR_W = (ADDR_BYTES > 0) ? ADDR_BYTES * 8 : 8;

  logic              start;
  logic [7:0]        cmd;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              done;
  logic [7:0]        data_out;
  logic              data_valid;
  logic              data_ready;
  logic              spi_cs_n;
  logic              tx_wr_en;
  logic [7:0]        tx_data;
  logic              tx_sent;
  logic              rx_rd_en;
  logic [7:0]        rx_data;
  logic              rx_received;

  modport master (
    input  start, cmd, addr, len, data_ready, tx_sent, rx_data, rx_received,
    output busy, done, data_out, data_valid, spi_cs_n, tx_wr_en, tx_data, rx_rd_en
  );

  modport slave (
    output start, cmd, addr, len, data_ready, tx_sent, rx_data, rx_received,
    input  busy, done, data_out, data_valid, spi_cs_n, tx_wr_en, tx_data, rx_rd_en
  );
endinterface

// File: rtl/spi_read_sequencer.sv
// rtl/spi_read_sequencer.sv - sequences command, address and read-data bytes of one SPI read
// All outputs are registered; shifter pulses appear the cycle after the decision.
module spi_read_sequencer #(
  parameter int ADDR_BYTES = 3,
  parameter int LEN_W      = 8,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  spi_read_sequencer_if.master bus
);
  localparam int ADDR_W   = (ADDR_BYTES > 0) ? ADDR_BYTES * 8 : 8;
  localparam int AL_W     = (ADDR_BYTES > 0) ? $clog2(ADDR_BYTES + 1) : 1;
  localparam int TICK_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int TICK_W   = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;

  localparam logic [TICK_W:0]  SETUP_TICKS = (TICK_W + 1)'(CS_SETUP);
  localparam logic [TICK_W:0]  HOLD_TICKS  = (TICK_W + 1)'(CS_HOLD);
  localparam logic [AL_W-1:0]  ADDR_COUNT  = AL_W'(ADDR_BYTES);
  localparam logic [LEN_W-1:0] LEN_ONE     = LEN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SU,
    S_TX_WAIT,
    S_RX_ISSUE,
    S_RX_WAIT,
    S_OUT,
    S_CS_HD
  } state_t;

  state_t            state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [TICK_W:0]   tick_next;
  logic [7:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [AL_W-1:0]   addr_left_q, addr_left_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cs_n_q, cs_n_d;
  logic              tx_wr_en_q, tx_wr_en_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              rx_rd_en_q, rx_rd_en_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    addr_left_d  = addr_left_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    cs_n_d       = cs_n_q;
    tx_wr_en_d   = 1'b0;
    tx_data_d    = tx_data_q;
    rx_rd_en_d   = 1'b0;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    tick_next    = {1'b0, tick_q} + {{TICK_W{1'b0}}, clk_en};

    unique case (state_q)
      S_IDLE: begin
        // done_q still high means this is the done cycle; a start here is dropped.
        if (bus.start && !done_q) begin
          cmd_d       = bus.cmd;
          addr_d      = bus.addr;
          addr_left_d = ADDR_COUNT;
          cnt_d       = bus.len;
          busy_d      = 1'b1;
          cs_n_d      = 1'b0;
          tick_d      = '0;
          state_d     = S_CS_SU;
        end
      end

      S_CS_SU: begin
        tick_d = tick_next[TICK_W-1:0];
        if (tick_next >= SETUP_TICKS) begin
          tx_wr_en_d = 1'b1;
          tx_data_d  = cmd_q;
          state_d    = S_TX_WAIT;
        end
      end

      S_TX_WAIT: begin
        if (bus.tx_sent) begin
          if (addr_left_q != '0) begin
            tx_wr_en_d  = 1'b1;
            tx_data_d   = addr_q[ADDR_W-1 -: 8];
            addr_d      = addr_q << 8;
            addr_left_d = addr_left_q - AL_W'(1);
          end else if (cnt_q != '0) begin
            state_d = S_RX_ISSUE;
          end else begin
            tick_d  = '0;
            state_d = S_CS_HD;
          end
        end
      end

      S_RX_ISSUE: begin
        rx_rd_en_d = 1'b1;
        state_d    = S_RX_WAIT;
      end

      S_RX_WAIT: begin
        if (bus.rx_received) begin
          data_out_d   = bus.rx_data;
          data_valid_d = 1'b1;
          state_d      = S_OUT;
        end
      end

      S_OUT: begin
        // Next RX byte is only issued once the held byte is taken.
        if (data_valid_q && bus.data_ready) begin
          data_valid_d = 1'b0;
          cnt_d        = cnt_q - LEN_ONE;
          if (cnt_q == LEN_ONE) begin
            tick_d  = '0;
            state_d = S_CS_HD;
          end else begin
            state_d = S_RX_ISSUE;
          end
        end
      end

      S_CS_HD: begin
        tick_d = tick_next[TICK_W-1:0];
        if (tick_next >= HOLD_TICKS) begin
          tick_d  = '0;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tick_q       <= '0;
      cmd_q        <= '0;
      addr_q       <= '0;
      addr_left_q  <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      tx_wr_en_q   <= 1'b0;
      tx_data_q    <= '0;
      rx_rd_en_q   <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      addr_left_q  <= addr_left_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cs_n_q       <= cs_n_d;
      tx_wr_en_q   <= tx_wr_en_d;
      tx_data_q    <= tx_data_d;
      rx_rd_en_q   <= rx_rd_en_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.spi_cs_n   = cs_n_q;
  assign bus.tx_wr_en   = tx_wr_en_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.rx_rd_en   = rx_rd_en_q;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;

endmodule

// File: tb/tb_spi_read_sequencer.sv
// tb/tb_spi_read_sequencer.sv - directed bench for spi_read_sequencer with TX/RX shifter models
// Stimulus changes 1 time unit after posedge; models and monitor sample on negedge.
module tb_spi_read_sequencer;
  logic clk = 1'b0;
  logic reset;
  logic clk_en;

  spi_read_sequencer_if #(.ADDR_BYTES(3), .LEN_W(8)) bus ();

  spi_read_sequencer #(
    .ADDR_BYTES(3),
    .LEN_W(8),
    .CS_SETUP(2),
    .CS_HOLD(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clk_en(clk_en),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int en_div = 1;
  int done_cnt = 0;
  int rx_rd_cnt = 0;
  int rd_while_valid = 0;
  int valid_cycles = 0;
  int cs_bad = 0;
  int tx_stable_bad = 0;
  int su_ticks = 0;
  int hd_ticks = 0;
  int hd_last = 0;
  bit su_done = 1'b0;
  logic prev_cs_n = 1'b1;
  logic [7:0] tx_log[$];
  logic [7:0] out_log[$];
  logic [7:0] rx_vals[$];
  int rx_idx = 0;

  // clk_en: one tick every en_div cycles
  initial begin
    int c;
    c = 0;
    clk_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      c++;
      clk_en = ((c % en_div) == 0);
    end
  end

  // TX shifter model
  initial begin
    logic [7:0] b;
    bus.tx_sent = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_wr_en === 1'b1) begin
        b = bus.tx_data;
        tx_log.push_back(b);
        repeat (3) begin
          @(negedge clk);
          if (bus.tx_data !== b) tx_stable_bad++;
        end
        @(posedge clk);
        #1 bus.tx_sent = 1'b1;
        @(posedge clk);
        #1 bus.tx_sent = 1'b0;
      end
    end
  end

  // RX shifter model
  initial begin
    bus.rx_received = 1'b0;
    bus.rx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.rx_rd_en === 1'b1) begin
        repeat (3) @(posedge clk);
        #1;
        bus.rx_data = (rx_idx < rx_vals.size()) ? rx_vals[rx_idx] : 8'hEE;
        rx_idx++;
        bus.rx_received = 1'b1;
        @(posedge clk);
        #1 bus.rx_received = 1'b0;
      end
    end
  end

  // Monitor: stream beats, pulses, CS setup/hold tick counts
  initial begin
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) done_cnt++;
      if (bus.rx_rd_en === 1'b1) rx_rd_cnt++;
      if (bus.rx_rd_en === 1'b1 && bus.data_valid === 1'b1) rd_while_valid++;
      if (bus.data_valid === 1'b1) valid_cycles++;
      if (bus.data_valid === 1'b1 && bus.data_ready === 1'b1) out_log.push_back(bus.data_out);
      if (bus.busy === 1'b1 && bus.spi_cs_n !== 1'b0) cs_bad++;
      if (bus.spi_cs_n === 1'b0 && prev_cs_n === 1'b1) begin
        su_ticks = 0;
        su_done = 1'b0;
        hd_ticks = 0;
      end
      if (bus.spi_cs_n === 1'b0) begin
        if (!su_done) begin
          if (bus.tx_wr_en === 1'b1) su_done = 1'b1;
          else if (clk_en === 1'b1) su_ticks++;
        end
        if ((bus.data_valid === 1'b1 && bus.data_ready === 1'b1) || bus.tx_sent === 1'b1) hd_ticks = 0;
        else if (clk_en === 1'b1) hd_ticks++;
      end else if (prev_cs_n === 1'b0) begin
        hd_last = hd_ticks;
      end
      prev_cs_n = bus.spi_cs_n;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    tx_log.delete();
    out_log.delete();
    done_cnt = 0;
    rx_rd_cnt = 0;
    rd_while_valid = 0;
    valid_cycles = 0;
    cs_bad = 0;
    tx_stable_bad = 0;
    hd_last = -1;
    rx_idx = 0;
  endtask

  task automatic do_start(input logic [7:0] c, input logic [23:0] a, input logic [7:0] l);
    step(1);
    bus.start = 1'b1;
    bus.cmd = c;
    bus.addr = a;
    bus.len = l;
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int s;
    s = done_cnt;
    for (int i = 0; i < maxc && done_cnt == s; i++) step(1);
    n_checks++;
    if (done_cnt == s) begin
      n_fail++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", tag, maxc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.cmd = 8'h00;
    bus.addr = 24'h000000;
    bus.len = 8'h00;
    bus.data_ready = 1'b0;
    step(3);
    reset = 1'b0;
    step(1);
    n_checks++; if (bus.spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %b expected 1", bus.spi_cs_n); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_checks++; if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.data_valid); end
    n_checks++; if (bus.tx_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_tx_wr_en: got %b expected 0", bus.tx_wr_en); end
    n_checks++; if (bus.rx_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rx_rd_en: got %b expected 0", bus.rx_rd_en); end
    n_checks++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", bus.tx_data); end
    n_checks++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h expected 00", bus.data_out); end
  endtask

  task automatic test_basic_read();
    logic [7:0] exp_tx[4];
    logic [7:0] exp_rx[4];
    exp_tx = '{8'h03, 8'h01, 8'h23, 8'h45};
    exp_rx = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    clear_logs();
    rx_vals = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    bus.data_ready = 1'b1;
    do_start(8'h03, 24'h012345, 8'd4);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", bus.busy); end
    n_checks++; if (bus.spi_cs_n !== 1'b0) begin n_fail++; $display("FAIL basic_cs_low: got %b expected 0", bus.spi_cs_n); end
    wait_done("basic", 400);
    n_checks++;
    if (tx_log.size() != 4) begin n_fail++; $display("FAIL basic_tx_count: got %0d expected 4", tx_log.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_checks++; if (tx_log[i] !== exp_tx[i]) begin n_fail++; $display("FAIL basic_tx_%0d: got %h expected %h", i, tx_log[i], exp_tx[i]); end
    end
    n_checks++;
    if (out_log.size() != 4) begin n_fail++; $display("FAIL basic_rx_count: got %0d expected 4", out_log.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_checks++; if (out_log[i] !== exp_rx[i]) begin n_fail++; $display("FAIL basic_rx_%0d: got %h expected %h", i, out_log[i], exp_rx[i]); end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
    n_checks++; if (cs_bad != 0) begin n_fail++; $display("FAIL basic_cs_held: got %0d high cycles expected 0", cs_bad); end
    n_checks++; if (su_ticks != 2) begin n_fail++; $display("FAIL basic_setup_ticks: got %0d expected 2", su_ticks); end
    n_checks++; if (hd_last != 2) begin n_fail++; $display("FAIL basic_hold_ticks: got %0d expected 2", hd_last); end
    n_checks++; if (tx_stable_bad != 0) begin n_fail++; $display("FAIL basic_tx_stable: got %0d changes expected 0", tx_stable_bad); end
    n_checks++; if (rx_rd_cnt != 4) begin n_fail++; $display("FAIL basic_rx_rd_count: got %0d expected 4", rx_rd_cnt); end
  endtask

  task automatic test_len_zero();
    logic [7:0] exp_tx[4];
    exp_tx = '{8'h9F, 8'hAB, 8'hCD, 8'hEF};
    clear_logs();
    bus.data_ready = 1'b1;
    do_start(8'h9F, 24'hABCDEF, 8'd0);
    wait_done("len0", 300);
    n_checks++;
    if (tx_log.size() != 4) begin n_fail++; $display("FAIL len0_tx_count: got %0d expected 4", tx_log.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_checks++; if (tx_log[i] !== exp_tx[i]) begin n_fail++; $display("FAIL len0_tx_%0d: got %h expected %h", i, tx_log[i], exp_tx[i]); end
    end
    n_checks++; if (rx_rd_cnt != 0) begin n_fail++; $display("FAIL len0_rx_rd: got %0d expected 0", rx_rd_cnt); end
    n_checks++; if (valid_cycles != 0) begin n_fail++; $display("FAIL len0_valid: got %0d cycles expected 0", valid_cycles); end
    n_checks++; if (hd_last != 2) begin n_fail++; $display("FAIL len0_hold_ticks: got %0d expected 2", hd_last); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL len0_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    logic [7:0] exp_rx[3];
    exp_rx = '{8'hB0, 8'hB1, 8'hB2};
    clear_logs();
    rx_vals = '{8'hB0, 8'hB1, 8'hB2};
    bus.data_ready = 1'b1;
    do_start(8'h0B, 24'h000100, 8'd3);
    for (int i = 0; i < 300 && out_log.size() < 1; i++) step(1);
    bus.data_ready = 1'b0;
    for (int i = 0; i < 100 && bus.data_valid !== 1'b1; i++) step(1);
    held = bus.data_out;
    n_checks++; if (held !== 8'hB1) begin n_fail++; $display("FAIL bp_byte2: got %h expected b1", held); end
    for (int k = 0; k < 10; k++) begin
      step(1);
      n_checks++; if (bus.data_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held_%0d: got %b expected 1", k, bus.data_valid); end
      n_checks++; if (bus.data_out !== held) begin n_fail++; $display("FAIL bp_data_stable_%0d: got %h expected %h", k, bus.data_out, held); end
    end
    n_checks++; if (rx_rd_cnt != 2) begin n_fail++; $display("FAIL bp_no_issue: got %0d rx_rd_en expected 2", rx_rd_cnt); end
    bus.data_ready = 1'b1;
    wait_done("bp", 300);
    n_checks++;
    if (out_log.size() != 3) begin n_fail++; $display("FAIL bp_rx_count: got %0d expected 3", out_log.size()); end
    else for (int i = 0; i < 3; i++) begin
      n_checks++; if (out_log[i] !== exp_rx[i]) begin n_fail++; $display("FAIL bp_rx_%0d: got %h expected %h", i, out_log[i], exp_rx[i]); end
    end
    n_checks++; if (rd_while_valid != 0) begin n_fail++; $display("FAIL bp_rd_while_valid: got %0d expected 0", rd_while_valid); end
    n_checks++; if (rx_rd_cnt != 3) begin n_fail++; $display("FAIL bp_rx_rd_count: got %0d expected 3", rx_rd_cnt); end
  endtask

  task automatic test_clk_en_slow();
    logic [7:0] exp_tx[4];
    exp_tx = '{8'h3B, 8'hFE, 8'hDC, 8'hBA};
    clear_logs();
    en_div = 4;
    rx_vals = '{8'h5A, 8'hC3};
    bus.data_ready = 1'b1;
    do_start(8'h3B, 24'hFEDCBA, 8'd2);
    wait_done("clken", 1500);
    en_div = 1;
    n_checks++; if (su_ticks != 2) begin n_fail++; $display("FAIL clken_setup_ticks: got %0d expected 2", su_ticks); end
    n_checks++; if (hd_last != 2) begin n_fail++; $display("FAIL clken_hold_ticks: got %0d expected 2", hd_last); end
    n_checks++;
    if (tx_log.size() != 4) begin n_fail++; $display("FAIL clken_tx_count: got %0d expected 4", tx_log.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_checks++; if (tx_log[i] !== exp_tx[i]) begin n_fail++; $display("FAIL clken_tx_%0d: got %h expected %h", i, tx_log[i], exp_tx[i]); end
    end
    n_checks++;
    if (out_log.size() != 2) begin n_fail++; $display("FAIL clken_rx_count: got %0d expected 2", out_log.size()); end
    else begin
      n_checks++; if (out_log[0] !== 8'h5A) begin n_fail++; $display("FAIL clken_rx_0: got %h expected 5a", out_log[0]); end
      n_checks++; if (out_log[1] !== 8'hC3) begin n_fail++; $display("FAIL clken_rx_1: got %h expected c3", out_log[1]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_tx[4];
    exp_tx = '{8'h03, 8'h00, 8'h00, 8'h10};
    clear_logs();
    rx_vals = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    bus.data_ready = 1'b1;
    do_start(8'h03, 24'h000040, 8'd4);
    for (int i = 0; i < 300 && rx_rd_cnt < 2; i++) step(1);
    n_checks++; if (rx_rd_cnt != 2) begin n_fail++; $display("FAIL rstmid_reach_byte2: got %0d expected 2", rx_rd_cnt); end
    #1 reset = 1'b1;
    #1;
    n_checks++; if (bus.spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL rstmid_cs_async: got %b expected 1", bus.spi_cs_n); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_async: got %b expected 0", bus.busy); end
    step(3);
    reset = 1'b0;
    step(10);
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d expected 0", done_cnt); end
    clear_logs();
    rx_vals = '{8'hD5};
    do_start(8'h03, 24'h000010, 8'd1);
    wait_done("rstmid_after", 300);
    n_checks++;
    if (tx_log.size() != 4) begin n_fail++; $display("FAIL rstmid_tx_count: got %0d expected 4", tx_log.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_checks++; if (tx_log[i] !== exp_tx[i]) begin n_fail++; $display("FAIL rstmid_tx_%0d: got %h expected %h", i, tx_log[i], exp_tx[i]); end
    end
    n_checks++;
    if (out_log.size() != 1) begin n_fail++; $display("FAIL rstmid_rx_count: got %0d expected 1", out_log.size()); end
    else begin
      n_checks++; if (out_log[0] !== 8'hD5) begin n_fail++; $display("FAIL rstmid_rx_0: got %h expected d5", out_log[0]); end
    end
  endtask

  task automatic test_start_ignored();
    clear_logs();
    rx_vals = '{8'hE1};
    bus.data_ready = 1'b1;
    do_start(8'h03, 24'h111111, 8'd1);
    step(3);
    bus.start = 1'b1;
    bus.cmd = 8'h77;
    bus.addr = 24'h222222;
    bus.len = 8'd5;
    step(1);
    bus.start = 1'b0;
    for (int i = 0; i < 300 && bus.done !== 1'b1; i++) step(1);
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL ign_done_seen: got %b expected 1", bus.done); end
    bus.start = 1'b1;
    bus.cmd = 8'h55;
    step(1);
    bus.start = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ign_done_cycle_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL ign_done_cycle_cs: got %b expected 1", bus.spi_cs_n); end
    step(40);
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL ign_done_count: got %0d expected 1", done_cnt); end
    n_checks++; if (tx_log.size() != 4) begin n_fail++; $display("FAIL ign_tx_count: got %0d expected 4", tx_log.size()); end
    n_checks++; if (rx_rd_cnt != 1) begin n_fail++; $display("FAIL ign_rx_rd_count: got %0d expected 1", rx_rd_cnt); end
    n_checks++;
    if (out_log.size() != 1) begin n_fail++; $display("FAIL ign_rx_count: got %0d expected 1", out_log.size()); end
    else begin
      n_checks++; if (out_log[0] !== 8'hE1) begin n_fail++; $display("FAIL ign_rx_0: got %h expected e1", out_log[0]); end
    end
  endtask

  task automatic test_len_max();
    clear_logs();
    rx_vals.delete();
    for (int i = 0; i < 255; i++) rx_vals.push_back(8'(i + 3));
    bus.data_ready = 1'b1;
    do_start(8'h0B, 24'h00FF00, 8'hFF);
    wait_done("lenmax", 5000);
    n_checks++; if (out_log.size() != 255) begin n_fail++; $display("FAIL lenmax_count: got %0d expected 255", out_log.size()); end
    n_checks++; if (rx_rd_cnt != 255) begin n_fail++; $display("FAIL lenmax_rx_rd: got %0d expected 255", rx_rd_cnt); end
    if (out_log.size() == 255) begin
      n_checks++; if (out_log[0] !== 8'h03) begin n_fail++; $display("FAIL lenmax_first: got %h expected 03", out_log[0]); end
      n_checks++; if (out_log[254] !== 8'h01) begin n_fail++; $display("FAIL lenmax_last: got %h expected 01", out_log[254]); end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL lenmax_done_count: got %0d expected 1", done_cnt); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_read();
    test_len_zero();
    test_backpressure();
    test_clk_en_slow();
    test_reset_mid();
    test_start_ignored();
    test_len_max();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
